ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, giving the clk cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum clk cycles from START entry to ACK completion (20 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port send, input, 1 bit: transmit request, sampled only in IDLE.
REQ-006 The block SHALL have port data_in, input, 8 bits: command byte, latched on an accepted send.
REQ-007 The block SHALL have port ps2_clk_in, input, 1 bit: raw PS/2 clock line, asynchronous.
REQ-008 The block SHALL have port ps2_data_in, input, 1 bit: raw PS/2 data line, asynchronous.
REQ-009 The block SHALL have port ps2_clk_low, output, 1 bit: 1 pulls the PS/2 clock low; 0 releases it (open-drain).
REQ-010 The block SHALL have port ps2_data_low, output, 1 bit: 1 pulls the PS/2 data line low; 0 releases it.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a transfer ends.
REQ-013 The block SHALL have port ack_err, output, 1 bit: valid with done; 1 means the device did not acknowledge.
REQ-014 The block SHALL have port timeout, output, 1 bit: valid with done; 1 means the transfer was aborted by the watchdog.

Function
REQ-015 The block SHALL synchronize ps2_clk_in and ps2_data_in through 2 flops, and SHALL detect a PS/2 falling edge ("fall") as previous synchronized value 1 and current synchronized value 0.
REQ-016 The state machine SHALL have the states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK and WAIT_IDLE.
REQ-017 IDLE: when send=1, the block SHALL latch data_in, compute the odd parity bit (~^data_in), clear the counters and go to INHIBIT on the next clk.
REQ-018 INHIBIT: ps2_clk_low SHALL be 1 and ps2_data_low SHALL be 0 for exactly INHIBIT_CYCLES cycles, after which the block SHALL go to START.
REQ-019 START: ps2_clk_low SHALL be 0 and ps2_data_low SHALL be 1 (start bit); on fall the block SHALL drive bit0 and go to DATA.
REQ-020 DATA: on each fall the block SHALL drive the next bit, LSB first (ps2_data_low = ~bit); after the fall that drives bit7, the next fall SHALL drive parity and move to PARITY.
REQ-021 PARITY: on fall the block SHALL release data (stop bit = 1) and go to STOP.
REQ-022 STOP: on fall the block SHALL sample synchronized data, record ack_err = sampled value (0 = ACK), and go to ACK.
REQ-023 ACK / WAIT_IDLE: the block SHALL wait until both synchronized lines are high, then pulse done for 1 cycle with ack_err and timeout valid, and return to IDLE.
REQ-024 A send asserted while busy=1 SHALL be ignored; data_in changes while busy SHALL NOT affect the transfer.
REQ-025 Falls seen in IDLE or INHIBIT SHALL be ignored.
REQ-026 The block SHALL never pull ps2_clk_low and ps2_data_low high together except for no cycle (the lines are never both pulled simultaneously).

Reset
REQ-027 Reset SHALL force IDLE asynchronously with ps2_clk_low=0, ps2_data_low=0, busy=0, done=0, ack_err=0, timeout=0, and all counters and synchronizers at their idle values (synchronizers = 1).
REQ-028 Reset mid-transfer SHALL release both lines immediately, without a done pulse.

Configuration
REQ-029 With macro PS2_TX_TIMEOUT_EN defined, the block SHALL count cycles from START entry; reaching TIMEOUT_CYCLES before the ACK state SHALL release both lines, pulse done with timeout=1 and ack_err=1, and return to IDLE.
REQ-030 Without PS2_TX_TIMEOUT_EN, the watchdog counter SHALL be absent, timeout SHALL be tied to 0, and the block SHALL wait indefinitely for device clocks.

Verification
REQ-031 Verification SHALL cover: send data_in=0xED with the device model acknowledging -> line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, ack_err=0.
REQ-032 Verification SHALL cover: send 0x01 and then 0x00 -> parity bits 0 and 1 respectively.
REQ-033 Verification SHALL cover: a device that leaves data high at the ACK clock -> done=1, ack_err=1, timeout=0.
REQ-034 Verification SHALL cover: with PS2_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=2000 and a device that never clocks -> done at START entry + 2000 cycles, timeout=1, and both lines released.
REQ-035 Verification SHALL cover: reset asserted in DATA after 3 bits -> ps2_clk_low=0, ps2_data_low=0 and busy=0 with no clk edge, and no done pulse.
REQ-036 Verification SHALL cover: send=1 with data_in=0x55 during a transfer of 0xF4 -> only 0xF4 is transmitted, and exactly one done pulse occurs.

Source files
------------

// File: rtl/ps2_host_tx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 command transmitter. It inhibits the bus, issues a
//   request-to-send, then shifts a start bit, 8 data bits (LSB first), odd
//   parity and a stop bit on the device-generated clock. It then samples the
//   device acknowledge and waits for the bus to go idle.
//
// Optional feature:
//   PS2_TX_TIMEOUT_EN - when defined, a watchdog aborts the transfer if the
//                       ACK state is not reached within TIMEOUT_CYCLES clk
//                       cycles of START entry. When undefined, timeout is
//                       tied to 0 and the block waits forever for the device.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before the start bit
//   TIMEOUT_CYCLES  watchdog limit, counted from START entry
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   send          transmit request, sampled only in IDLE
//   data_in[7:0]  command byte, latched on an accepted send
//   ps2_clk_in    raw PS/2 clock line (asynchronous)
//   ps2_data_in   raw PS/2 data line (asynchronous)
//   ps2_clk_low   1 pulls the PS/2 clock low, 0 releases it (open drain)
//   ps2_data_low  1 pulls the PS/2 data line low, 0 releases it
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a transfer ends
//   ack_err       valid with done: device did not acknowledge
//   timeout       valid with done: transfer aborted by the watchdog
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             clk_s;
  logic             data_s;
  logic             fall;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_idx;   // index of the next data bit to drive
  logic [7:0]       data_reg;
  logic             par_reg;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the pre-edge values; blocking assignments would make the
  // synchronizer chain collapse into a single flop in simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Synchronizers reset to 1 (idle bus) so no false fall appears after reset.
      clk_sync     <= 2'b11;
      data_sync    <= 2'b11;
      clk_prev     <= 1'b1;
      state        <= IDLE;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      inh_cnt      <= '0;
      bit_idx      <= '0;
      data_reg     <= '0;
      par_reg      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (send) begin
            data_reg    <= data_in;
            par_reg     <= ~^data_in;
            inh_cnt     <= '0;
            bit_idx     <= '0;
            ack_err     <= 1'b0;
            ps2_clk_low <= 1'b1;
            busy        <= 1'b1;
            state       <= INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            // Release clock and pull data in the same edge: never both pulled.
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b1;
            state        <= START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        START: begin
          if (fall) begin
            ps2_data_low <= ~data_reg[0];
            bit_idx      <= 4'd1;
            state        <= DATA;
          end
        end

        DATA: begin
          if (fall) begin
            if (bit_idx == 4'd8) begin
              ps2_data_low <= ~par_reg;
              state        <= PARITY;
            end else begin
              ps2_data_low <= ~data_reg[bit_idx[2:0]];
              bit_idx      <= bit_idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (fall) begin
            ps2_data_low <= 1'b0;  // stop bit is a released line
            state        <= STOP;
          end
        end

        STOP: begin
          if (fall) begin
            ack_err <= data_s;  // device pulls data low to acknowledge
            state   <= ACK;
          end
        end

        // Let the device finish its acknowledge clock pulse first.
        ACK: begin
          if (clk_s) state <= WAIT_IDLE;
        end

        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog runs from START entry until ACK; it overrides the case above.
      if (state inside {START, DATA, PARITY, STOP}) begin
        if (wd_cnt == WD_LAST) begin
          ps2_clk_low  <= 1'b0;
          ps2_data_low <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b1;
          ack_err      <= 1'b1;
          timeout_q    <= 1'b1;
          state        <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Scoreboard bench for ps2_host_tx. Stimulus pushes the expected result of
//   each transfer into a queue; a monitor pops and compares on every done
//   pulse. A behavioural device model drives the open-drain bus, records the
//   frame it sees and optionally acknowledges.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 200;  // device clock half period, ns

  typedef struct {
    logic [10:0] frame;    // {stop, parity, data[7:0], start}
    logic        ack_err;
    logic        timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ps2_clk_low, ps2_data_low, busy, done, ack_err, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  exp_t        exp_q[$];
  exp_t        e;
  logic [10:0] dev_frame;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_count = 0;
  int          n_exp = 0;
  int          both_pulled = 0;
  int          cyc = 0;
  int          done_cyc = 0;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_low;
  assign ps2_data_line = dev_data & ~ps2_data_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .send        (send),
    .data_in     (data_in),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_low (ps2_clk_low),
    .ps2_data_low(ps2_data_low),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (ps2_clk_low && ps2_data_low) both_pulled++;
    if (done) begin
      done_count++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_err", ack_err, e.ack_err);
        check("timeout", timeout, e.timeout);
        if (!e.timeout) check("frame", dev_frame, e.frame);
        check("clk_released", ps2_clk_low, 1'b0);
        check("data_released", ps2_data_low, 1'b0);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic push_exp(input logic [10:0] frame, input logic ack_e, input logic tmo);
    exp_t x;
    x.frame   = frame;
    x.ack_err = ack_e;
    x.timeout = tmo;
    exp_q.push_back(x);
    n_exp++;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    data_in = ~d;  // changing data_in while busy must not matter
  endtask

  // Device model: waits for request-to-send, then generates n_clk clock
  // pulses, sampling the data line in the middle of each high phase.
  task automatic device_run(input int n_clk, input bit ack);
    int guard = 0;
    dev_frame = '0;
    while (!(ps2_data_low && !ps2_clk_low) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("rts_seen", (guard < 5000) ? 32'd1 : 32'd0, 32'd1);
    if (guard < 5000) begin
      #(HALF);
      dev_frame[0] = ps2_data_line;
      for (int i = 1; i <= n_clk; i++) begin
        if (i == 11 && ack) begin
          dev_data = 1'b0;
          #(HALF / 2);
        end
        dev_clk = 1'b0;
        #(HALF);
        dev_clk = 1'b1;
        #(HALF / 2);
        if (i <= 10) dev_frame[i] = ps2_data_line;
        #(HALF / 2);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", (done_count >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int inh_len;
    int t_start;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_clk_low", ps2_clk_low, 1'b0);
    check("rst_data_low", ps2_data_low, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED acknowledged: bits 1,0,1,1,0,1,1,1, parity 1. Also inhibit length.
    push_exp({1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b0);
    send_byte(8'hED);
    check("busy_after_send", busy, 1'b1);
    inh_len = 0;
    while (ps2_clk_low && inh_len < 1000) begin
      inh_len++;
      @(negedge clk);
    end
    check("inhibit_len", inh_len, INH);
    device_run(11, 1'b1);
    wait_done(n_exp);

    // 0x01 -> parity 0, 0x00 -> parity 1.
    push_exp({1'b1, 1'b0, 8'h01, 1'b0}, 1'b0, 1'b0);
    send_byte(8'h01);
    device_run(11, 1'b1);
    wait_done(n_exp);

    push_exp({1'b1, 1'b1, 8'h00, 1'b0}, 1'b0, 1'b0);
    send_byte(8'h00);
    device_run(11, 1'b1);
    wait_done(n_exp);

    // Device leaves data high at the ACK clock.
    push_exp({1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0);
    send_byte(8'hFF);
    device_run(11, 1'b0);
    wait_done(n_exp);

    // Send while busy with a different byte: only 0xF4 goes out.
    push_exp({1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0, 1'b0);
    send_byte(8'hF4);
    repeat (4) @(negedge clk);
    data_in = 8'h55;
    send    = 1'b1;
    repeat (3) @(negedge clk);
    send    = 1'b0;
    data_in = 8'hAA;
    device_run(11, 1'b1);
    wait_done(n_exp);
    repeat (50) @(negedge clk);
    check("single_done", done_count, n_exp);

    // Reset in DATA after 3 bits: lines released with no clk edge, no done.
    send_byte(8'hA3);
    device_run(3, 1'b0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_clk_low", ps2_clk_low, 1'b0);
    check("mid_rst_data_low", ps2_data_low, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("no_done_after_rst", done_count, n_exp);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: done exactly TMO cycles after START entry.
    push_exp(11'h000, 1'b1, 1'b1);
    send_byte(8'h3C);
    t_start = 0;
    while (!ps2_data_low && t_start < 1000) begin
      @(negedge clk);
      t_start++;
    end
    t_start = cyc;
    wait_done(n_exp);
    check("timeout_latency", done_cyc - t_start, TMO);
    repeat (10) @(negedge clk);
    check("tmo_busy", busy, 1'b0);
`else
    t_start = 0;
`endif

    check("never_both_pulled", both_pulled, 0);
    check("total_done", done_count, n_exp);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
